// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: registered forwarding selects, load-use stalls, branch flush sequencing.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters; otherwise they read 0.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 31,
    parameter int BR_FLUSH   = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_rm,
    input  logic                  id_uses_rn,
    input  logic                  id_uses_rm,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_branch_taken,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [REG_ADDR_W-1:0] ZR      = REG_ADDR_W'(ZERO_REG);
    localparam logic [1:0]            FC_INIT = (BR_FLUSH > 1) ? 2'(BR_FLUSH - 2) : 2'd0;

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } sh_ex_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } sh_mem_t;

    state_e     state_q;
    logic [1:0] fc_q;
    sh_ex_t     sh_ex_q, sh_ex_d;
    sh_mem_t    sh_mem_q;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       lu, br_active, stall, flush, id_load;

    // EX/MEM wins over MEM/WB; a load still in EX cannot forward (that case stalls instead).
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_ADDR_W-1:0] src,
                                           input sh_ex_t ex, input sh_mem_t mem);
        fwd_sel = 2'b00;
        if (used && src != ZR) begin
            if (ex.valid && ex.regwrite && !ex.memread && ex.rd == src)
                fwd_sel = 2'b10;
            else if (mem.valid && mem.regwrite && mem.rd == src)
                fwd_sel = 2'b01;
        end
    endfunction

    // NOTE: every signal gets a value on every path through always_comb so no latch is inferred.
    always_comb begin
        lu = sh_ex_q.valid && sh_ex_q.memread && sh_ex_q.rd != ZR && id_valid &&
             ((id_uses_rn && id_rn == sh_ex_q.rd) || (id_uses_rm && id_rm == sh_ex_q.rd));
        br_active = (state_q == ST_FLUSH) || ex_branch_taken;
        flush     = !rst && br_active;
        stall     = !rst && !br_active && lu;
        id_load   = id_valid && !(flush || stall);

        sh_ex_d = '0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (id_load) begin
            sh_ex_d.valid    = 1'b1;
            sh_ex_d.rd       = id_rd;
            sh_ex_d.regwrite = id_regwrite;
            sh_ex_d.memread  = id_memread;
            fwd_a_d = fwd_sel(id_uses_rn, id_rn, sh_ex_q, sh_mem_q);
            fwd_b_d = fwd_sel(id_uses_rm, id_rm, sh_ex_q, sh_mem_q);
        end
    end

    assign pc_stall     = stall;
    assign if_id_stall  = stall;
    assign if_id_flush  = flush;
    assign id_ex_bubble = stall || flush;
    assign fwd_a        = fwd_a_q;
    assign fwd_b        = fwd_b_q;

    // Branch sequencer: the RUN cycle that sees the branch is the first flush cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            fc_q    <= 2'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken && BR_FLUSH > 1) begin
                        state_q <= ST_FLUSH;
                        fc_q    <= FC_INIT;
                    end
                end
                ST_FLUSH: begin
                    if (fc_q == 2'd0)
                        state_q <= ST_RUN;
                    else
                        fc_q <= fc_q - 2'd1;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_ex_q  <= '0;
            sh_mem_q <= '0;
            fwd_a_q  <= 2'b00;
            fwd_b_q  <= 2'b00;
        end else begin
            sh_ex_q  <= sh_ex_d;
            sh_mem_q <= '{valid: sh_ex_q.valid, rd: sh_ex_q.rd, regwrite: sh_ex_q.regwrite};
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against an instruction-level pipeline model.
// Counter expectations follow HAZARD_PERF_CNT_EN the same way the design does.
module tb_pipeline_hazard_ctrl;

    localparam int BR_FLUSH = 3;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rn, id_uses_rm, id_regwrite, id_memread, ex_branch_taken;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(5), .ZERO_REG(31), .BR_FLUSH(BR_FLUSH), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Model: the instructions currently in EX and MEM, plus how many flush cycles remain.
    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    instr_t m_ex, m_mem;
    int     m_flush_left;
    int     m_fwd_a, m_fwd_b;
    longint m_stalls, m_flushes;
    bit     e_stall, e_flush, e_bubble;
    int     vectors = 0, miscompares = 0;
    int     seen_stall = 0, seen_flush = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input longint n);
        logic [31:0] sat;
        sat = (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(n);
        return CNT_EN ? sat : 32'd0;
    endfunction

    // Operand source for a register read, given the producers ahead of it.
    function automatic int src_sel(input bit used, input int src);
        if (!used || src == 31) return 0;
        if (m_ex.valid && m_ex.wr && !m_ex.ld && m_ex.rd == src) return 2;
        if (m_mem.valid && m_mem.wr && m_mem.rd == src) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_ex = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        m_mem = m_ex;
        m_flush_left = 0;
        m_fwd_a = 0;
        m_fwd_b = 0;
        m_stalls = 0;
        m_flushes = 0;
    endtask

    task automatic model_comb();
        bit br, lu;
        br = (m_flush_left > 0) || ex_branch_taken;
        lu = id_valid && m_ex.valid && m_ex.ld && m_ex.rd != 31 &&
             ((id_uses_rn && int'(id_rn) == m_ex.rd) || (id_uses_rm && int'(id_rm) == m_ex.rd));
        e_flush  = br;
        e_stall  = !br && lu;
        e_bubble = e_flush || e_stall;
    endtask

    task automatic model_step();
        bit adv;
        adv = id_valid && !e_bubble;
        m_fwd_a = adv ? src_sel(id_uses_rn, int'(id_rn)) : 0;
        m_fwd_b = adv ? src_sel(id_uses_rm, int'(id_rm)) : 0;
        m_mem = m_ex;
        if (adv) m_ex = '{valid: 1'b1, rd: int'(id_rd), wr: id_regwrite, ld: id_memread};
        else     m_ex = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        if (e_stall) m_stalls++;
        if (e_flush) m_flushes++;
        if (m_flush_left > 0)     m_flush_left--;
        else if (ex_branch_taken) m_flush_left = BR_FLUSH - 1;
    endtask

    task automatic drive(input bit v, input int rn, input int rm, input bit urn, input bit urm,
                         input int rd, input bit rw, input bit mr, input bit br);
        id_valid = v;
        id_rn = 5'(rn);
        id_rm = 5'(rm);
        id_uses_rn = urn;
        id_uses_rm = urm;
        id_rd = 5'(rd);
        id_regwrite = rw;
        id_memread = mr;
        ex_branch_taken = br;
    endtask

    // Called just after a rising edge with inputs already driven; ends just after the next rising edge.
    task automatic run_cycle(input string tag);
        model_comb();
        @(negedge clk);
        check({tag, ":pc_stall"},     32'(pc_stall),     32'(e_stall));
        check({tag, ":if_id_stall"},  32'(if_id_stall),  32'(e_stall));
        check({tag, ":if_id_flush"},  32'(if_id_flush),  32'(e_flush));
        check({tag, ":id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bubble));
        if (pc_stall === 1'b1) seen_stall++;
        if (if_id_flush === 1'b1) seen_flush++;
        model_step();
        @(posedge clk);
        #1;
        check({tag, ":fwd_a"},     32'(fwd_a), 32'(m_fwd_a));
        check({tag, ":fwd_b"},     32'(fwd_b), 32'(m_fwd_b));
        check({tag, ":stall_cnt"}, stall_cnt,  exp_cnt(m_stalls));
        check({tag, ":flush_cnt"}, flush_cnt,  exp_cnt(m_flushes));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":pc_stall"},     32'(pc_stall),     32'd0);
        check({tag, ":if_id_stall"},  32'(if_id_stall),  32'd0);
        check({tag, ":if_id_flush"},  32'(if_id_flush),  32'd0);
        check({tag, ":id_ex_bubble"}, 32'(id_ex_bubble), 32'd0);
        check({tag, ":fwd_a"},        32'(fwd_a),        32'd0);
        check({tag, ":fwd_b"},        32'(fwd_b),        32'd0);
        check({tag, ":stall_cnt"},    stall_cnt,         32'd0);
        check({tag, ":flush_cnt"},    flush_cnt,         32'd0);
    endtask

    // Reset with hazard-provoking inputs applied, so the output gating is exercised.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        drive(1, 3, 3, 1, 1, 3, 1, 1, 1);
        #1;
        check_all_zero({tag, ":in_rst"});
        @(posedge clk);
        #1;
        check_all_zero({tag, ":rst_edge"});
        rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int pick_reg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 31 : r;
    endfunction

    initial begin
        model_reset();
        do_reset("por");

        // EX/MEM forwarding to rn, no stall
        drive(1, 5, 6, 1, 1, 1, 1, 0, 0);  run_cycle("add_x1");
        drive(1, 1, 7, 1, 1, 8, 1, 0, 0);  run_cycle("sub_rn1");
        check("exfwd:fwd_a", 32'(fwd_a), 32'd2);
        check("exfwd:fwd_b", 32'(fwd_b), 32'd0);

        // EX priority over MEM, then MEM-only forwarding on the B port
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0);  run_cycle("w2_a");
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0);  run_cycle("w2_b");
        drive(1, 0, 2, 0, 1, 10, 1, 0, 0); run_cycle("rd_rm2_ex");
        check("expri:fwd_b", 32'(fwd_b), 32'd2);
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0);  run_cycle("w2_c");
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0);  run_cycle("w9");
        drive(1, 0, 2, 0, 1, 10, 1, 0, 0); run_cycle("rd_rm2_mem");
        check("memfwd:fwd_b", 32'(fwd_b), 32'd1);

        // Load-use: one stall cycle, then MEM/WB forwarding
        seen_stall = 0;
        drive(1, 10, 0, 1, 0, 3, 1, 1, 0); run_cycle("ldur_x3");
        drive(1, 3, 11, 1, 1, 12, 1, 0, 0); run_cycle("use_x3_stall");
        run_cycle("use_x3_go");
        check("lu:stall_cycles", 32'(seen_stall), 32'd1);
        check("lu:fwd_a", 32'(fwd_a), 32'd1);
        check("lu:stall_cnt", stall_cnt, CNT_EN ? 32'd1 : 32'd0);

        // XZR is never a hazard or forwarding source
        seen_stall = 0;
        drive(1, 0, 0, 0, 0, 31, 1, 0, 0);  run_cycle("add_xzr");
        drive(1, 31, 31, 1, 1, 13, 1, 0, 0); run_cycle("rd_xzr");
        check("xzr:fwd_a", 32'(fwd_a), 32'd0);
        check("xzr:fwd_b", 32'(fwd_b), 32'd0);
        drive(1, 0, 0, 0, 0, 31, 1, 1, 0);  run_cycle("ld_xzr");
        drive(1, 31, 31, 1, 1, 13, 1, 0, 0); run_cycle("rd_xzr_ld");
        check("xzr:no_stall", 32'(seen_stall), 32'd0);

        // Branch coincident with a load-use: flush wins for BR_FLUSH cycles
        do_reset("pre_br");
        seen_stall = 0;
        seen_flush = 0;
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0); run_cycle("ldur_x4");
        drive(1, 4, 0, 1, 0, 5, 1, 0, 1); run_cycle("br_lu");
        drive(1, 4, 0, 1, 0, 5, 1, 0, 0); run_cycle("br_f2");
        run_cycle("br_f3");
        run_cycle("br_done");
        check("br:flush_cycles", 32'(seen_flush), 32'(BR_FLUSH));
        check("br:stall_cycles", 32'(seen_stall), 32'd0);
        check("br:flush_cnt", flush_cnt, CNT_EN ? 32'(BR_FLUSH) : 32'd0);
        check("br:stall_cnt", stall_cnt, 32'd0);

        // Reset in the second flush cycle aborts the flush
        drive(1, 0, 0, 0, 0, 6, 1, 0, 1); run_cycle("br2");
        drive(1, 0, 0, 0, 0, 6, 1, 0, 0);
        #2;
        check("mid:flush_before_rst", 32'(if_id_flush), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        seen_flush = 0;
        drive(1, 0, 0, 0, 0, 6, 1, 0, 0); run_cycle("post_rst_run");
        check("post_rst:no_flush", 32'(seen_flush), 32'd0);
        drive(1, 0, 0, 0, 0, 6, 1, 0, 1); run_cycle("br3");
        drive(1, 0, 0, 0, 0, 6, 1, 0, 0); run_cycle("br3_f2");
        run_cycle("br3_f3");
        run_cycle("br3_done");
        check("br3:flush_cycles", 32'(seen_flush), 32'(BR_FLUSH));

        // Randomized traffic over a small register set to provoke frequent matches
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7) != 0, pick_reg(), pick_reg(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_reg(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
            run_cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
